// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bus between decode/writeback and the scoreboarded register file.
//
// Parameters: XLEN (data width), AW (address width).
// Signals:
//   A1, A2      read addresses              RD1, RD2     read data
//   Pend1,Pend2 pending bits of A1/A2       A3, WD3      write address/data
//   RegWEn      write enable (clears pend)  RsvEn        reserve enable
//   RsvAddr     register to reserve         Ready        array valid, traffic accepted
// Modports: master (pipeline side), slave (register file side).
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   A1, A2, A3, RsvAddr;
    logic [XLEN-1:0] RD1, RD2, WD3;
    logic            Pend1, Pend2, RegWEn, RsvEn, Ready;

    modport master (
        output A1, A2, A3, WD3, RegWEn, RsvEn, RsvAddr,
        input  RD1, RD2, Pend1, Pend2, Ready
    );

    modport slave (
        input  A1, A2, A3, WD3, RegWEn, RsvEn, RsvAddr,
        output RD1, RD2, Pend1, Pend2, Ready
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- scoreboarded register file: two combinational read ports,
// one synchronous write port, and a per-register pending bit that is set
// by a reservation and cleared by the matching writeback. Reset starts a
// sweep that clears one register per cycle; Ready stays low until done.
//
// Parameters: XLEN (register width), AW (address width, NREG = 2**AW).
// Ports:
//   clock  rising-edge clock
//   Reset  synchronous, active-high; restarts the sweep even mid-sweep
//   bus    regfile_sb_if.slave (reads, write, reserve, Ready)
// Optional feature: define REGFILE_BYPASS_EN to forward the write port to
// the read ports in the same cycle.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic         clock,
    input  logic         Reset,
    regfile_sb_if.slave  bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_pend;

    logic            w_ready;
    logic            w_wr;
    logic            w_rsv;
    logic [XLEN-1:0] w_rd1, w_rd2;
    logic            w_p1, w_p2;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (Reset) r_state <= S_CLEAR;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        // Last register is cleared on this edge, array is fully zeroed.
        if (r_state == S_CLEAR && r_cnt == '1)
            w_next = S_READY;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready = (r_state == S_READY);
    end

    assign bus.Ready = w_ready;

    // Sweep counter wraps to 0 exactly when leaving CLEAR.
    always_ff @(posedge clock) begin
        if (Reset)                  r_cnt <= '0;
        else if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
    end

    // x0 is never written or reserved.
    assign w_wr  = w_ready & bus.RegWEn & (bus.A3 != '0);
    assign w_rsv = w_ready & bus.RsvEn  & (bus.RsvAddr != '0);

    always_ff @(posedge clock) begin
        if (!Reset) begin
            if (r_state == S_CLEAR) r_mem[r_cnt]  <= '0;
            else if (w_wr)          r_mem[bus.A3] <= bus.WD3;
        end
    end

    // Reservation is applied after the writeback clear so that a younger
    // instruction reserving the same register keeps it pending.
    always_ff @(posedge clock) begin
        if (Reset) begin
            r_pend <= '0;
        end else begin
            if (w_wr)  r_pend[bus.A3]      <= 1'b0;
            if (w_rsv) r_pend[bus.RsvAddr] <= 1'b1;
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        w_p1  = 1'b0;
        w_p2  = 1'b0;
        if (w_ready) begin
            if (bus.A1 != '0) begin
                w_rd1 = r_mem[bus.A1];
                w_p1  = r_pend[bus.A1];
            end
            if (bus.A2 != '0) begin
                w_rd2 = r_mem[bus.A2];
                w_p2  = r_pend[bus.A2];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the writeback; a same-cycle reservation of the same
            // register still shows it as pending.
            if (w_wr && bus.A3 == bus.A1) begin
                w_rd1 = bus.WD3;
                w_p1  = w_rsv && (bus.RsvAddr == bus.A1);
            end
            if (w_wr && bus.A3 == bus.A2) begin
                w_rd2 = bus.WD3;
                w_p2  = w_rsv && (bus.RsvAddr == bus.A2);
            end
`else
            // Stored state only; writes appear on the next cycle.
`endif
        end
    end

    assign bus.RD1   = w_rd1;
    assign bus.RD2   = w_rd2;
    assign bus.Pend1 = w_p1;
    assign bus.Pend2 = w_p2;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- randomized scoreboard bench for regfile_sb. A driver
// issues one operation per cycle and pushes the expected read-port view
// computed from a behavioural model; a monitor pops and compares it.
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    logic clock = 1'b0;
    logic Reset = 1'b0;
    always #5 clock = ~clock;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_sb #(.XLEN(XLEN), .AW(AW)) dut (
        .clock (clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [XLEN-1:0] rd1, rd2;
        logic            p1, p2, rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: architectural state plus how many sweep cycles remain.
    logic [XLEN-1:0] mem_m  [NREG];
    logic            pend_m [NREG];
    logic            ready_m = 1'b0;
    int              left_m  = 0;
    logic            model_valid = 1'b0;

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t expect_out(input logic [AW-1:0] a1, a2, a3, ra,
                                        input logic [XLEN-1:0] wd, input logic we, rsv);
        exp_t e;
        e.rdy = ready_m;
        e.rd1 = '0; e.rd2 = '0; e.p1 = 1'b0; e.p2 = 1'b0;
        if (ready_m) begin
            if (a1 != 0) begin e.rd1 = mem_m[a1]; e.p1 = pend_m[a1]; end
            if (a2 != 0) begin e.rd2 = mem_m[a2]; e.p2 = pend_m[a2]; end
`ifdef REGFILE_BYPASS_EN
            if (we && a3 != 0 && a3 == a1) begin e.rd1 = wd; e.p1 = rsv && ra == a1; end
            if (we && a3 != 0 && a3 == a2) begin e.rd2 = wd; e.p2 = rsv && ra == a2; end
`endif
        end
        return e;
    endfunction

    task automatic step(input logic rst, input logic [AW-1:0] a1, a2, a3,
                        input logic [XLEN-1:0] wd, input logic we, rsv,
                        input logic [AW-1:0] ra);
        @(negedge clock);
        Reset = rst;
        bus.A1 = a1; bus.A2 = a2; bus.A3 = a3; bus.WD3 = wd;
        bus.RegWEn = we; bus.RsvEn = rsv; bus.RsvAddr = ra;
        if (model_valid) exp_q.push_back(expect_out(a1, a2, a3, ra, wd, we, rsv));
        @(posedge clock);
        if (rst) begin
            model_valid = 1'b1;
            ready_m = 1'b0;
            left_m  = NREG;
            for (int i = 0; i < NREG; i++) pend_m[i] = 1'b0;
        end else if (!ready_m) begin
            left_m--;
            if (left_m == 0) begin
                ready_m = 1'b1;
                for (int i = 0; i < NREG; i++) mem_m[i] = '0;
            end
        end else begin
            if (we && a3 != 0) begin mem_m[a3] = wd; pend_m[a3] = 1'b0; end
            if (rsv && ra != 0) pend_m[ra] = 1'b1;
        end
    endtask

    task automatic rd(input logic [AW-1:0] a1, a2);
        step(1'b0, a1, a2, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: outputs are combinational, so sample once inputs have settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("Ready", {31'b0, bus.Ready}, {31'b0, e.rdy});
                check("RD1",   bus.RD1,            e.rd1);
                check("RD2",   bus.RD2,            e.rd2);
                check("Pend1", {31'b0, bus.Pend1}, {31'b0, e.p1});
                check("Pend2", {31'b0, bus.Pend2}, {31'b0, e.p2});
            end
        end
    end

    initial begin
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WD3 = '0;
        bus.RegWEn = 1'b0; bus.RsvEn = 1'b0; bus.RsvAddr = '0;

        // Reset, then restart the sweep at edge 10.
        step(1'b1, 5'd5, 5'd0, '0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) rd(5'd5, 5'd4);
        step(1'b1, 5'd5, 5'd0, '0, '0, 1'b0, 1'b0, '0);
        // Sweep with write/reserve traffic on x4, which must be ignored.
        for (int i = 0; i < NREG; i++)
            step(1'b0, 5'd5, 5'd4, 5'd4, 32'hFFFF_0000 + i, 1'b1, 1'b1, 5'd4);
        rd(5'd4, 5'd5);

        // Write/read and x0.
        step(1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        rd(5'd0, 5'd7);
        step(1'b0, 5'd0, 5'd7, 5'd0, 32'h1234, 1'b1, 1'b1, 5'd0);
        rd(5'd0, 5'd7);

        // Scoreboard: reserve, writeback, simultaneous reserve + writeback.
        step(1'b0, 5'd3, 5'd7, '0, '0, 1'b0, 1'b1, 5'd3);
        rd(5'd3, 5'd7);
        step(1'b0, 5'd3, 5'd0, 5'd3, 32'h55, 1'b1, 1'b0, '0);
        rd(5'd3, 5'd0);
        step(1'b0, 5'd3, 5'd0, 5'd3, 32'h55, 1'b1, 1'b1, 5'd3);
        rd(5'd3, 5'd0);

        // Same-cycle read of the register being written.
        step(1'b0, 5'd9, 5'd9, 5'd9, 32'hA5A5A5A5, 1'b1, 1'b0, '0);
        rd(5'd9, 5'd9);

        // Random traffic, biased toward a few registers to force collisions.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] a1, a2, a3, ra;
            a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
            a3 = AW'($urandom_range(0, 7));
            ra = AW'($urandom_range(0, 7));
            step($urandom_range(0, 399) == 0, a1, a2, a3, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ra);
        end

        @(negedge clock);
        #4;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0 pending", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised scoreboarded register file for the pipelined RISC-V core. It provides two combinational read ports and one synchronous write port, plus a per-register pending bit set when a long-latency result (load, multi-cycle op) is issued and cleared when that result is written back. On Reset it does not clear the array in one cycle: a sweep state machine clears one register per cycle and holds `Ready` low until the sweep is done. It sits between decode (reads, hazard check) and writeback.

## Interface
- `XLEN`, default 32: register width in bits.
- `AW`, default 5: address width; `NREG = 2**AW` registers.
- `clock`  in  1  rising-edge clock.
- `Reset`  in  1  reset: synchronous, active-high (decided).
- `A1`, `A2`  in  AW  read addresses.
- `RD1`, `RD2`  out  XLEN  read data for `A1`/`A2`.
- `Pend1`, `Pend2`  out  1  pending bit of register `A1`/`A2`.
- `A3`  in  AW  write address.
- `WD3`  in  XLEN  write data.
- `RegWEn`  in  1  write enable; also clears the pending bit of `A3`.
- `RsvEn`  in  1  reserve enable: sets the pending bit of `RsvAddr`.
- `RsvAddr`  in  AW  register to reserve.
- `Ready`  out  1  high when the array is valid and writes/reservations are accepted.

## Operation
- **States:**
  - CLEAR: entered whenever `Reset` is sampled high, including mid-sweep, which restarts the sweep. On that edge, sweep counter `cnt <= 0` and all pending bits `<= 0`.
  - In CLEAR with `Reset=0`, each edge does `RegMem[cnt] <= 0`, `cnt <= cnt+1`. When `cnt == NREG-1` the state goes to READY.
  - READY: normal operation; stays there until `Reset`.
- **Register 0:** reads `0`; its pending bit reads `0`; writes and reservations to address 0 are ignored.
- **Write (READY):** `RegWEn=1`, `A3!=0` → `RegMem[A3] <= WD3` and `pend[A3] <= 0`.
- **Reserve (READY):** `RsvEn=1`, `RsvAddr!=0` → `pend[RsvAddr] <= 1`.
- **Same edge, `RegWEn` and `RsvEn` on the same address:** data is written and the pending bit ends at `1`. The reservation wins because it belongs to a younger instruction.
- **In CLEAR:** `RegWEn` and `RsvEn` are ignored. `RD1`, `RD2`, `Pend1`, `Pend2` are forced to `0`.
- **Arithmetic:** no arithmetic on data. `cnt` is AW bits and wraps only at the CLEAR→READY transition.

## Timing
- Reads are combinational from the stored array: zero latency.
- A write is visible on `RD*` from the cycle after the write edge (without bypass).
- **`Ready` timing:**
  - `Ready=0` from the edge that samples `Reset=1`.
  - `Ready=1` after the NREG-th subsequent edge with `Reset=0`; this is 32 edges for `AW=5`.
- **Reset values:** `Ready=0`, `RD1=RD2=0`, `Pend1=Pend2=0`, all pending bits `0`. Array contents are zero once the sweep completes.
- Before the first `Reset`, all outputs are undefined; `Reset` is mandatory after power-up.
- `Pend*` reflect pending bits updated at the edge. A reservation asserted at edge k is visible on `Pend*` in cycle k+1.

## Configuration
- Macro `REGFILE_BYPASS_EN` compiles in a write-through bypass.
- **Defined:** in READY, if `RegWEn=1` and `A3!=0`:
  - If `A3==A1`, `RD1 = WD3` in the same cycle, and `Pend1=0` unless `RsvEn=1` with `RsvAddr==A1`.
  - The same rule applies to `A2`/`RD2`/`Pend2`.
- **Undefined:** `RD*` and `Pend*` show stored state only. The written value and the cleared pending bit appear one cycle later.

## Test plan
- Reset sweep: `Reset=1` for 1 edge, then 0 → `Ready=0` for 32 edges, `Ready=1` after edge 32. `RD1` for `A1=5` is 0 throughout.
- Reset mid-sweep: reassert `Reset` at sweep edge 10 → counter restarts, and `Ready` rises 32 edges after the second reset.
- Write/read: write `x7=0xDEADBEEF` → next cycle `RD2=0xDEADBEEF` for `A2=7`. A write to `x0` of `0x1234` leaves `RD1=0` for `A1=0`.
- Scoreboard:
  - `RsvEn`, `RsvAddr=3` → `Pend1=1` for `A1=3` next cycle.
  - Write `x3=0x55` → `Pend1=0` and `RD1=0x55` next cycle.
  - Simultaneous reserve+write of `x3` → `Pend1` stays 1 and `RD1=0x55`.
- Bypass (`REGFILE_BYPASS_EN` defined): `A1=A3=9`, `RegWEn=1`, `WD3=0xA5A5A5A5` → `RD1=0xA5A5A5A5` in the same cycle. Without the macro, `RD1` shows the old value that cycle and the new value next cycle.
- CLEAR ignores traffic: `RegWEn=1`, `RsvEn=1` on `x4` during the sweep → after `Ready`, `RD1=0` and `Pend1=0` for `A1=4`.
